// File: rtl/game_pkg.sv
// Shared game-board constants: FSM encodings, player colours, grid split points
// and the eight winning lines, kept common with the draw and highlight stages.
package game_pkg;

    localparam int NUM_SQUARES = 9;

    localparam logic BLUE   = 1'b0;
    localparam logic YELLOW = 1'b1;

    localparam logic [11:0] H_SPLIT1_DEF = 12'd344;
    localparam logic [11:0] H_SPLIT2_DEF = 12'd680;
    localparam logic [11:0] H_MAX_DEF    = 12'd1023;
    localparam logic [11:0] V_SPLIT1_DEF = 12'd252;
    localparam logic [11:0] V_SPLIT2_DEF = 12'd504;
    localparam logic [11:0] V_MAX_DEF    = 12'd767;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_HIT    = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Three rows, three columns, two diagonals (square indices 0..8).
    localparam logic [3:0] LINE_TBL [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Returns {line_found, owning_player}; first complete line wins.
    function automatic logic [1:0] line_winner(input logic [8:0] sq, input logic [8:0] own);
        logic [1:0] res;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        res = 2'b00;
        for (int l = 0; l < 8; l++) begin
            a = LINE_TBL[l][0];
            b = LINE_TBL[l][1];
            c = LINE_TBL[l][2];
            if (!res[1] && sq[a] && sq[b] && sq[c] && (own[a] == own[b]) && (own[b] == own[c])) begin
                res = {1'b1, own[a]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/square_ctl_if.sv
// Mouse/control inputs and board-state outputs of square_ctl.
// Win ports exist only when SQUARE_CTL_WIN_DETECT_EN is defined.
interface square_ctl_if;

    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        start_en;
    logic        choice_en;
    logic        new_game;
    logic [8:0]  square;
    logic [8:0]  owner;
    logic        turn;
    logic [3:0]  move_cnt;
    logic        board_full;
    logic        move_valid;
`ifdef SQUARE_CTL_WIN_DETECT_EN
    logic        win;
    logic        winner;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        input  square, owner, turn, move_cnt, board_full, move_valid, win, winner
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        output square, owner, turn, move_cnt, board_full, move_valid, win, winner
    );
`else
    modport master (
        output mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        input  square, owner, turn, move_cnt, board_full, move_valid
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        output square, owner, turn, move_cnt, board_full, move_valid
    );
`endif

endinterface

// File: rtl/square_hit.sv
// Combinational cursor-to-square mapper: column, row, square index and
// in-bounds flag. Shared with the cursor-highlight stage.
module square_hit
    import game_pkg::*;
#(
    parameter logic [11:0] H_SPLIT1 = H_SPLIT1_DEF,
    parameter logic [11:0] H_SPLIT2 = H_SPLIT2_DEF,
    parameter logic [11:0] H_MAX    = H_MAX_DEF,
    parameter logic [11:0] V_SPLIT1 = V_SPLIT1_DEF,
    parameter logic [11:0] V_SPLIT2 = V_SPLIT2_DEF,
    parameter logic [11:0] V_MAX    = V_MAX_DEF
) (
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [1:0]  col,
    output logic [1:0]  row,
    output logic [3:0]  idx,
    output logic        valid
);

    always_comb begin
        col = 2'd2;
        if (xpos < H_SPLIT1) begin
            col = 2'd0;
        end else if (xpos < H_SPLIT2) begin
            col = 2'd1;
        end

        row = 2'd2;
        if (ypos < V_SPLIT1) begin
            row = 2'd0;
        end else if (ypos < V_SPLIT2) begin
            row = 2'd1;
        end

        // row*3 + col without a multiplier
        idx   = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
        valid = (xpos <= H_MAX) && (ypos <= V_MAX);
    end

endmodule

// File: rtl/square_ctl.sv
// Game-board controller: turns left-click edges into square claims, tracks
// occupancy/owner/turn. Optional line detection under SQUARE_CTL_WIN_DETECT_EN.
module square_ctl
    import game_pkg::*;
#(
    parameter logic [11:0] H_SPLIT1 = H_SPLIT1_DEF,
    parameter logic [11:0] H_SPLIT2 = H_SPLIT2_DEF,
    parameter logic [11:0] H_MAX    = H_MAX_DEF,
    parameter logic [11:0] V_SPLIT1 = V_SPLIT1_DEF,
    parameter logic [11:0] V_SPLIT2 = V_SPLIT2_DEF,
    parameter logic [11:0] V_MAX    = V_MAX_DEF
) (
    input logic        pclk,
    input logic        rst_n,
    square_ctl_if.slave bus
);

    // state  | meaning
    // IDLE   | game inactive, board held clear
    // WAIT   | waiting for a click edge
    // HIT    | map latched coordinates to a square, reject out-of-range/occupied
    // COMMIT | claim the square, flip turn, count the move
    // DONE   | board full (or line won), clicks ignored

    logic [2:0]             state;
    logic                   mouse_left_q;
    logic [11:0]            x_lat;
    logic [11:0]            y_lat;
    logic [NUM_SQUARES-1:0] square_q;
    logic [NUM_SQUARES-1:0] owner_q;
    logic                   turn_q;
    logic [3:0]             move_cnt_q;
    logic                   board_full_q;
    logic                   move_valid_q;
    logic                   check_q;
    logic                   click;
    logic [3:0]             cnt_next;
    logic [1:0]             hit_col_unused;
    logic [1:0]             hit_row_unused;
    logic [3:0]             hit_idx;
    logic                   hit_valid;

    square_hit #(
        .H_SPLIT1 (H_SPLIT1),
        .H_SPLIT2 (H_SPLIT2),
        .H_MAX    (H_MAX),
        .V_SPLIT1 (V_SPLIT1),
        .V_SPLIT2 (V_SPLIT2),
        .V_MAX    (V_MAX)
    ) u_hit (
        .xpos  (x_lat),
        .ypos  (y_lat),
        .col   (hit_col_unused),
        .row   (hit_row_unused),
        .idx   (hit_idx),
        .valid (hit_valid)
    );

    assign click    = bus.mouse_left & ~mouse_left_q;
    assign cnt_next = move_cnt_q + 4'd1;

`ifdef SQUARE_CTL_WIN_DETECT_EN
    logic       win_q;
    logic       winner_q;
    logic [1:0] line_res;

    assign line_res   = line_winner(square_q, owner_q);
    assign bus.win    = win_q;
    assign bus.winner = winner_q;
`else
    logic unused_check;
    assign unused_check = check_q;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mouse_left_q <= 1'b0;
            x_lat        <= '0;
            y_lat        <= '0;
            square_q     <= '0;
            owner_q      <= '0;
            turn_q       <= BLUE;
            move_cnt_q   <= '0;
            board_full_q <= 1'b0;
            move_valid_q <= 1'b0;
            check_q      <= 1'b0;
`ifdef SQUARE_CTL_WIN_DETECT_EN
            win_q        <= 1'b0;
            winner_q     <= BLUE;
`endif
        end else begin
            mouse_left_q <= bus.mouse_left;
            move_valid_q <= 1'b0;
            check_q      <= 1'b0;

            // Clear outranks any click or commit landing in the same cycle.
            if (!bus.start_en || bus.new_game) begin
                state        <= (bus.start_en && bus.new_game) ? ST_WAIT : ST_IDLE;
                square_q     <= '0;
                owner_q      <= '0;
                turn_q       <= BLUE;
                move_cnt_q   <= '0;
                board_full_q <= 1'b0;
`ifdef SQUARE_CTL_WIN_DETECT_EN
                win_q        <= 1'b0;
                winner_q     <= BLUE;
`endif
            end
`ifdef SQUARE_CTL_WIN_DETECT_EN
            else if (check_q && line_res[1]) begin
                win_q    <= 1'b1;
                winner_q <= line_res[0];
                state    <= ST_DONE;
            end
`endif
            else begin
                case (state)
                    ST_IDLE: begin
                        if (!bus.choice_en) begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (!bus.choice_en && click) begin
                            x_lat <= bus.mouse_xpos;
                            y_lat <= bus.mouse_ypos;
                            state <= ST_HIT;
                        end
                    end
                    ST_HIT: begin
                        if (bus.choice_en || !hit_valid || square_q[hit_idx]) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        if (bus.choice_en) begin
                            state <= ST_WAIT;
                        end else begin
                            square_q[hit_idx] <= 1'b1;
                            owner_q[hit_idx]  <= turn_q;
                            turn_q            <= (turn_q == BLUE) ? YELLOW : BLUE;
                            move_cnt_q        <= cnt_next;
                            board_full_q      <= (cnt_next == 4'd9);
                            move_valid_q      <= 1'b1;
                            check_q           <= 1'b1;
                            state             <= (cnt_next == 4'd9) ? ST_DONE : ST_WAIT;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.square     = square_q;
    assign bus.owner      = owner_q;
    assign bus.turn       = turn_q;
    assign bus.move_cnt   = move_cnt_q;
    assign bus.board_full = board_full_q;
    assign bus.move_valid = move_valid_q;

endmodule

// File: tb/tb_square_ctl.sv
// Directed plus randomized bench for square_ctl against a board-level model
// (arrays of occupancy/owner, turn and move count).
module tb_square_ctl;

    logic pclk;
    logic rst_n;

    square_ctl_if bus ();

    square_ctl dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    bit occ_m [9];
    bit own_m [9];
    bit turn_m;
    int cnt_m;
    bit done_m;
    bit win_m;
    bit winner_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 9; i++) begin
            occ_m[i] = 1'b0;
            own_m[i] = 1'b0;
        end
        turn_m   = 1'b0;
        cnt_m    = 0;
        done_m   = 1'b0;
        win_m    = 1'b0;
        winner_m = 1'b0;
    endtask

    function automatic bit line_done(input int a, input int b, input int c);
        return occ_m[a] && occ_m[b] && occ_m[c] && (own_m[a] == own_m[b]) && (own_m[b] == own_m[c]);
    endfunction

    task automatic model_win_check();
        for (int k = 0; k < 3; k++) begin
            if (!win_m && line_done(3*k, 3*k+1, 3*k+2)) begin win_m = 1; winner_m = own_m[3*k]; end
            if (!win_m && line_done(k, k+3, k+6))       begin win_m = 1; winner_m = own_m[k]; end
        end
        if (!win_m && line_done(0, 4, 8)) begin win_m = 1; winner_m = own_m[0]; end
        if (!win_m && line_done(2, 4, 6)) begin win_m = 1; winner_m = own_m[2]; end
    endtask

    task automatic model_click(input int x, input int y, output int exp_mv);
        int col;
        int row;
        int idx;
        exp_mv = 0;
        if (done_m || x > 1023 || y > 767) return;
        col = (x < 344) ? 0 : (x < 680) ? 1 : 2;
        row = (y < 252) ? 0 : (y < 504) ? 1 : 2;
        idx = row * 3 + col;
        if (occ_m[idx]) return;
        occ_m[idx] = 1'b1;
        own_m[idx] = turn_m;
        turn_m     = ~turn_m;
        cnt_m++;
        exp_mv = 1;
        if (cnt_m == 9) done_m = 1'b1;
`ifdef SQUARE_CTL_WIN_DETECT_EN
        model_win_check();
        if (win_m) done_m = 1'b1;
`endif
    endtask

    task automatic check_board(input string tag);
        logic [8:0] sq_e;
        logic [8:0] own_e;
        for (int i = 0; i < 9; i++) begin
            sq_e[i]  = occ_m[i];
            own_e[i] = occ_m[i] & own_m[i];
        end
        chk({tag, ".square"},     16'(bus.square),     16'(sq_e));
        chk({tag, ".owner"},      16'(bus.owner),      16'(own_e));
        chk({tag, ".turn"},       16'(bus.turn),       16'(turn_m));
        chk({tag, ".move_cnt"},   16'(bus.move_cnt),   16'(cnt_m));
        chk({tag, ".board_full"}, 16'(bus.board_full), 16'(cnt_m == 9));
`ifdef SQUARE_CTL_WIN_DETECT_EN
        chk({tag, ".win"},        16'(bus.win),        16'(win_m));
        chk({tag, ".winner"},     16'(bus.winner),     16'(winner_m));
`endif
    endtask

    task automatic do_click(input int x, input int y, input string tag);
        int exp_mv;
        int mv;
        model_click(x, y, exp_mv);
        mv = 0;
        @(negedge pclk);
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
        bus.mouse_left = 1'b1;
        @(negedge pclk);
        mv += int'(bus.move_valid);
        bus.mouse_left = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            mv += int'(bus.move_valid);
        end
        chk({tag, ".move_valid"}, 16'(mv), 16'(exp_mv));
        check_board(tag);
    endtask

    task automatic pulse_new_game();
        @(negedge pclk);
        bus.new_game = 1'b1;
        @(negedge pclk);
        bus.new_game = 1'b0;
        model_clear();
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv;
        int exp_mv;
        int rx;
        int ry;

        rst_n          = 1'b0;
        bus.mouse_xpos = '0;
        bus.mouse_ypos = '0;
        bus.mouse_left = 1'b0;
        bus.start_en   = 1'b0;
        bus.choice_en  = 1'b0;
        bus.new_game   = 1'b0;
        model_clear();

        repeat (3) @(negedge pclk);
        check_board("reset");
        chk("reset.move_valid", 16'(bus.move_valid), 16'h0);
        rst_n = 1'b1;
        @(negedge pclk);
        bus.start_en = 1'b1;
        repeat (3) @(negedge pclk);

        do_click(500, 100, "first");
        do_click(500, 100, "repeat");
        do_click(10, 600, "second");
        do_click(343, 251, "edge_low");
        do_click(344, 252, "edge_high");
        do_click(1030, 100, "x_range");
        do_click(100, 800, "y_range");

        // Held button: one edge, one claim
        model_click(900, 400, exp_mv);
        mv = 0;
        @(negedge pclk);
        bus.mouse_xpos = 12'd900;
        bus.mouse_ypos = 12'd400;
        bus.mouse_left = 1'b1;
        repeat (50) begin
            @(negedge pclk);
            mv += int'(bus.move_valid);
        end
        bus.mouse_left = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            mv += int'(bus.move_valid);
        end
        chk("hold.move_valid", 16'(mv), 16'(exp_mv));
        check_board("hold");

        // choice_en raised while the FSM is in HIT: the click is discarded
        mv = 0;
        @(negedge pclk);
        bus.mouse_xpos = 12'd900;
        bus.mouse_ypos = 12'd100;
        bus.mouse_left = 1'b1;
        @(negedge pclk);
        bus.mouse_left = 1'b0;
        bus.choice_en  = 1'b1;
        @(negedge pclk);
        mv += int'(bus.move_valid);
        bus.choice_en  = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            mv += int'(bus.move_valid);
        end
        chk("choice_abort.move_valid", 16'(mv), 16'h0);
        check_board("choice_abort");

        // Full board, no line: B0 Y1 B2 Y4 B3 Y5 B7 Y6 B8
        pulse_new_game();
        check_board("new_game");
        do_click(100, 100, "draw1");
        do_click(500, 100, "draw2");
        do_click(900, 100, "draw3");
        do_click(500, 400, "draw4");
        do_click(100, 400, "draw5");
        do_click(900, 400, "draw6");
        do_click(500, 700, "draw7");
        do_click(100, 700, "draw8");
        do_click(900, 700, "draw9");
        do_click(500, 400, "after_full");

        // new_game together with a click: clear wins, click lost
        @(negedge pclk);
        bus.new_game   = 1'b1;
        bus.mouse_xpos = 12'd100;
        bus.mouse_ypos = 12'd100;
        bus.mouse_left = 1'b1;
        @(negedge pclk);
        bus.new_game   = 1'b0;
        bus.mouse_left = 1'b0;
        model_clear();
        repeat (6) @(negedge pclk);
        check_board("new_game_click");
        do_click(500, 700, "after_clear");

`ifdef SQUARE_CTL_WIN_DETECT_EN
        // Squares 1,4,2,5,3: blue completes the top row
        pulse_new_game();
        do_click(100, 100, "win1");
        do_click(100, 400, "win2");
        do_click(500, 100, "win3");
        do_click(500, 400, "win4");
        do_click(900, 100, "win5");
        chk("win.flag", 16'(bus.win), 16'h1);
        do_click(900, 700, "after_win");
`endif

        // Random clicks over and beyond the board
        pulse_new_game();
        for (int n = 0; n < 60; n++) begin
            if (done_m) begin
                pulse_new_game();
                check_board("rand_clear");
            end
            rx = int'($urandom_range(0, 1100));
            ry = int'($urandom_range(0, 820));
            do_click(rx, ry, "rand");
        end

        // Asynchronous reset asserted while the FSM sits in COMMIT
        pulse_new_game();
        do_click(100, 100, "pre_reset");
        @(negedge pclk);
        bus.mouse_xpos = 12'd500;
        bus.mouse_ypos = 12'd100;
        bus.mouse_left = 1'b1;
        @(negedge pclk);
        bus.mouse_left = 1'b0;
        @(negedge pclk);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_board("async_reset");
        chk("async_reset.move_valid", 16'(bus.move_valid), 16'h0);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);
        do_click(900, 700, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
